stack_pointer_unit: RTL and testbench

Parametrised stack-pointer unit, successor to the 16-bit inc/dec/write stack-pointer register. Adds:
- push/pop with configurable step and a bounded stack window
- sticky overflow, underflow and write-range fault flags
- full/empty status
- shadow pointer swapped in one cycle on interrupt entry/exit

Drives the address path for stack accesses in the datapath; the control unit issues push/pop/swap/write strobes.

---
 rtl/stack_pointer_unit.sv | 138 +++++++++++++
 tb/tb_stack_pointer_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/stack_pointer_unit.sv
// stack_pointer_unit: bounded, downward-growing stack pointer with a shadow
// pointer for interrupt entry/exit, push/pop by STEP, full/empty status and
// sticky overflow/underflow/write-range fault flags.
// Optional build macro STACK_POINTER_UNIT_HWM_EN adds a highWater output that
// tracks the deepest (lowest) pointer value reached.
module stack_pointer_unit #(
    parameter int unsigned      WIDTH       = 16,
    parameter logic [WIDTH-1:0] STEP        = WIDTH'(1),
    parameter logic [WIDTH-1:0] LIMIT_LO    = WIDTH'(16'h0100),
    parameter logic [WIDTH-1:0] LIMIT_HI    = WIDTH'(16'h01FF),
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(16'h01FF)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] writeData,
    input  logic             write,
    input  logic             push,
    input  logic             pop,
    input  logic             swap,
    input  logic             clearFlags,
    output logic [WIDTH-1:0] Data,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow,
    output logic             writeFault
`ifdef STACK_POINTER_UNIT_HWM_EN
    ,
    output logic [WIDTH-1:0] highWater
`endif
);

    // The single operation that wins this cycle after priority resolution.
    typedef enum logic [2:0] {
        OP_IDLE,
        OP_WRITE,
        OP_SWAP,
        OP_PUSH,
        OP_POP
    } op_e;

    op_e            op;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             overflow_q, underflow_q, write_fault_q;
    logic             overflow_set, underflow_set, write_fault_set;
    logic [WIDTH:0]   down;
    logic [WIDTH:0]   up;
    logic             push_ok, pop_ok, write_ok;

    // One extra bit catches the borrow/carry so the pointer can never wrap.
    assign down     = {1'b0, data_q} - {1'b0, STEP};
    assign up       = {1'b0, data_q} + {1'b0, STEP};
    assign push_ok  = !down[WIDTH] && (down[WIDTH-1:0] >= LIMIT_LO);
    assign pop_ok   = (up <= {1'b0, LIMIT_HI});
    assign write_ok = (writeData >= LIMIT_LO) && (writeData <= LIMIT_HI);

    // Priority: write > swap > push/pop; push and pop together cancel out.
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
        op = OP_IDLE;
        if (write)             op = OP_WRITE;
        else if (swap)         op = OP_SWAP;
        else if (push && !pop) op = OP_PUSH;
        else if (pop && !push) op = OP_POP;
    end

    // Next pointer/shadow values and fault events for the winning operation.
    always_comb begin
        data_d          = data_q;
        shadow_d        = shadow_q;
        overflow_set    = 1'b0;
        underflow_set   = 1'b0;
        write_fault_set = 1'b0;
        case (op)
            OP_WRITE: begin
                if (write_ok) data_d = writeData;
                else          write_fault_set = 1'b1;
            end
            OP_SWAP: begin
                data_d   = shadow_q;
                shadow_d = data_q;
            end
            OP_PUSH: begin
                if (push_ok) data_d = down[WIDTH-1:0];
                else         overflow_set = 1'b1;
            end
            OP_POP: begin
                if (pop_ok) data_d = up[WIDTH-1:0];
                else        underflow_set = 1'b1;
            end
            default: ;
        endcase
    end

    // Pointer, shadow and sticky flags; a fault in the clearing cycle still sets its flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_q        <= RESET_VALUE;
            shadow_q      <= RESET_VALUE;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
            write_fault_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            data_q        <= data_d;
            shadow_q      <= shadow_d;
            overflow_q    <= (overflow_q & ~clearFlags) | overflow_set;
            underflow_q   <= (underflow_q & ~clearFlags) | underflow_set;
            write_fault_q <= (write_fault_q & ~clearFlags) | write_fault_set;
        end
    end

`ifdef STACK_POINTER_UNIT_HWM_EN
    logic [WIDTH-1:0] hwm_q;

    // Deepest pointer value seen; clearFlags restarts tracking from the new pointer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hwm_q <= RESET_VALUE;
        end else if (clearFlags) begin
            hwm_q <= data_d;
        end else if (data_d < hwm_q) begin
            hwm_q <= data_d;
        end
    end

    assign highWater = hwm_q;
`endif

    assign Data       = data_q;
    assign empty      = (data_q == LIMIT_HI);
    assign full       = !push_ok;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;
    assign writeFault = write_fault_q;

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Self-checking bench for stack_pointer_unit: table of directed vectors plus
// hand-written sequences for reset, the full boundary, STEP=2 and high-water.
// highWater is checked only when STACK_POINTER_UNIT_HWM_EN is defined.
module tb_stack_pointer_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] write_data;
    logic        wr, pu, po, sw, cl;
    logic [15:0] data;
    logic        empty, full, overflow, underflow, write_fault;

    logic [15:0] b_write_data;
    logic        b_wr, b_pu, b_po, b_sw, b_cl;
    logic [15:0] b_data;
    logic        b_empty, b_full, b_overflow, b_underflow, b_write_fault;

`ifdef STACK_POINTER_UNIT_HWM_EN
    logic [15:0] high_water, b_high_water;
`endif

    always #5 clock = ~clock;

    stack_pointer_unit dut (
        .clock(clock), .reset(reset), .writeData(write_data), .write(wr),
        .push(pu), .pop(po), .swap(sw), .clearFlags(cl),
        .Data(data), .empty(empty), .full(full), .overflow(overflow),
        .underflow(underflow), .writeFault(write_fault)
`ifdef STACK_POINTER_UNIT_HWM_EN
        , .highWater(high_water)
`endif
    );

    stack_pointer_unit #(.STEP(16'd2)) dut_step2 (
        .clock(clock), .reset(reset), .writeData(b_write_data), .write(b_wr),
        .push(b_pu), .pop(b_po), .swap(b_sw), .clearFlags(b_cl),
        .Data(b_data), .empty(b_empty), .full(b_full), .overflow(b_overflow),
        .underflow(b_underflow), .writeFault(b_write_fault)
`ifdef STACK_POINTER_UNIT_HWM_EN
        , .highWater(b_high_water)
`endif
    );

    typedef struct {
        logic        wr;
        logic [15:0] wd;
        logic        pu, po, sw, cl;
        logic [15:0] e_data;
        logic        e_empty, e_full, e_ov, e_un, e_wf;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_a(input string name, input logic [15:0] e_data, input logic e_empty,
                           input logic e_full, input logic e_ov, input logic e_un, input logic e_wf);
        check({name, ".Data"}, 32'(data), 32'(e_data));
        check({name, ".empty"}, 32'(empty), 32'(e_empty));
        check({name, ".full"}, 32'(full), 32'(e_full));
        check({name, ".overflow"}, 32'(overflow), 32'(e_ov));
        check({name, ".underflow"}, 32'(underflow), 32'(e_un));
        check({name, ".writeFault"}, 32'(write_fault), 32'(e_wf));
    endtask

    task automatic check_b(input string name, input logic [15:0] e_data, input logic e_full,
                           input logic e_ov, input logic e_un);
        check({name, ".Data"}, 32'(b_data), 32'(e_data));
        check({name, ".full"}, 32'(b_full), 32'(e_full));
        check({name, ".overflow"}, 32'(b_overflow), 32'(e_ov));
        check({name, ".underflow"}, 32'(b_underflow), 32'(e_un));
    endtask

    // Drive one cycle of strobes on the STEP=1 unit, sample 1 time unit after the edge.
    task automatic step(input logic w, input logic [15:0] wd, input logic p_u,
                        input logic p_o, input logic s, input logic c);
        @(negedge clock);
        wr = w; write_data = wd; pu = p_u; po = p_o; sw = s; cl = c;
        @(posedge clock);
        #1;
        wr = 1'b0; pu = 1'b0; po = 1'b0; sw = 1'b0; cl = 1'b0;
    endtask

    task automatic step_b(input logic w, input logic [15:0] wd, input logic p_u,
                          input logic p_o, input logic c);
        @(negedge clock);
        b_wr = w; b_write_data = wd; b_pu = p_u; b_po = p_o; b_cl = c;
        @(posedge clock);
        #1;
        b_wr = 1'b0; b_pu = 1'b0; b_po = 1'b0; b_cl = 1'b0;
    endtask

    function automatic vec_t mk(input logic w, input logic [15:0] wd, input logic p_u,
                                input logic p_o, input logic s, input logic c,
                                input logic [15:0] ed, input logic ee, input logic ef,
                                input logic eo, input logic eu, input logic ew);
        vec_t v;
        v.wr = w; v.wd = wd; v.pu = p_u; v.po = p_o; v.sw = s; v.cl = c;
        v.e_data = ed; v.e_empty = ee; v.e_full = ef; v.e_ov = eo; v.e_un = eu; v.e_wf = ew;
        return v;
    endfunction

    initial begin
        // Vectors continue from Data=0x0100 (full) with all flags clear and shadow=0x01FF.
        //             wr  wd        pu po sw cl  Data      emp full ov un wf
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 16'h0100, 0, 1, 1, 0, 0)); // push at full
        vecs.push_back(mk(0, 16'h0000, 0, 0, 0, 1, 16'h0100, 0, 1, 0, 0, 0)); // clear
        vecs.push_back(mk(1, 16'h01FF, 0, 0, 0, 0, 16'h01FF, 1, 0, 0, 0, 0)); // write top
        vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 0, 16'h01FF, 1, 0, 0, 1, 0)); // pop at empty
        vecs.push_back(mk(0, 16'h0000, 0, 0, 0, 1, 16'h01FF, 1, 0, 0, 0, 0)); // clear
        vecs.push_back(mk(1, 16'h0180, 0, 0, 0, 0, 16'h0180, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 1, 0, 0, 16'h0180, 0, 0, 0, 0, 0)); // push+pop
        vecs.push_back(mk(1, 16'h0150, 0, 0, 0, 0, 16'h0150, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 16'h0050, 0, 0, 0, 0, 16'h0150, 0, 0, 0, 0, 1)); // out of range
        vecs.push_back(mk(1, 16'h0170, 1, 0, 0, 0, 16'h0170, 0, 0, 0, 0, 1)); // write beats push
        vecs.push_back(mk(1, 16'h0200, 0, 0, 0, 1, 16'h0170, 0, 0, 0, 0, 1)); // set beats clear
        vecs.push_back(mk(0, 16'h0000, 0, 0, 0, 1, 16'h0170, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 16'h0150, 0, 0, 0, 0, 16'h0150, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 0, 16'h01FF, 1, 0, 0, 0, 0)); // swap in shadow
        vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 0, 16'h0150, 0, 0, 0, 0, 0)); // swap back
        vecs.push_back(mk(0, 16'h0000, 0, 1, 1, 0, 16'h01FF, 1, 0, 0, 0, 0)); // swap beats pop
        vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 0, 16'h01FF, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 16'h01FF, 1, 0, 0, 1, 0)); // idle holds
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 1, 16'h01FE, 0, 0, 0, 0, 0)); // push + clear
        vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 0, 16'h01FF, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 0, 16'h0150, 0, 0, 0, 0, 0)); // shadow kept
        vecs.push_back(mk(1, 16'h0100, 0, 0, 0, 0, 16'h0100, 0, 1, 0, 0, 0)); // write LIMIT_LO
        vecs.push_back(mk(1, 16'h00FF, 0, 0, 0, 0, 16'h0100, 0, 1, 0, 0, 1)); // just below
        vecs.push_back(mk(1, 16'h0200, 0, 0, 0, 0, 16'h0100, 0, 1, 0, 0, 1)); // just above
        vecs.push_back(mk(0, 16'h0000, 0, 0, 0, 1, 16'h0100, 0, 1, 0, 0, 0));

        reset = 1'b0;
        wr = 0; pu = 0; po = 0; sw = 0; cl = 0; write_data = '0;
        b_wr = 0; b_pu = 0; b_po = 0; b_sw = 0; b_cl = 0; b_write_data = '0;
        repeat (2) @(negedge clock);
        reset = 1'b1;

        step(0, 16'h0, 0, 0, 0, 0);
        check_a("reset", 16'h01FF, 1, 0, 0, 0, 0);

        // Reset asserted mid-operation, between clock edges.
        step(0, 16'h0, 1, 0, 0, 0);
        step(0, 16'h0, 1, 0, 0, 0);
        step(0, 16'h0, 1, 0, 0, 0);
        check("pre_reset.Data", 32'(data), 32'h01FC);
        @(negedge clock);
        pu = 1'b1;
        #2 reset = 1'b0;
        #1 check("async_reset.Data", 32'(data), 32'h01FF);
        pu = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        step(0, 16'h0, 0, 0, 0, 0);
        check_a("reset_release", 16'h01FF, 1, 0, 0, 0, 0);

        for (int i = 0; i < 16'hFF; i++) step(0, 16'h0, 1, 0, 0, 0);
        check_a("push_to_full", 16'h0100, 0, 1, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].wr, vecs[i].wd, vecs[i].pu, vecs[i].po, vecs[i].sw, vecs[i].cl);
            check_a($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_empty, vecs[i].e_full,
                    vecs[i].e_ov, vecs[i].e_un, vecs[i].e_wf);
        end

        // STEP=2 unit near both limits.
        check_b("s2_reset", 16'h01FF, 0, 0, 0);
        step_b(1, 16'h0101, 0, 0, 0);
        check_b("s2_write", 16'h0101, 1, 0, 0);
        step_b(0, 16'h0, 1, 0, 0);
        check_b("s2_push_refused", 16'h0101, 1, 1, 0);
        step_b(0, 16'h0, 0, 0, 1);
        check_b("s2_clear", 16'h0101, 1, 0, 0);
        step_b(1, 16'h0102, 0, 0, 0);
        check_b("s2_at_0102", 16'h0102, 0, 0, 0);
        step_b(0, 16'h0, 1, 0, 0);
        check_b("s2_push_ok", 16'h0100, 1, 0, 0);
        step_b(0, 16'h0, 0, 1, 0);
        check_b("s2_pop", 16'h0102, 0, 0, 0);
        step_b(1, 16'h01FE, 0, 0, 0);
        step_b(0, 16'h0, 0, 1, 0);
        check_b("s2_pop_refused", 16'h01FE, 0, 0, 1);

        // High-water tracking on the STEP=1 unit.
        step(1, 16'h01FF, 0, 0, 0, 1);
        check("hwm_restart.Data", 32'(data), 32'h01FF);
`ifdef STACK_POINTER_UNIT_HWM_EN
        check("hwm_restart.highWater", 32'(high_water), 32'h01FF);
`endif
        for (int i = 0; i < 16'hDF; i++) step(0, 16'h0, 1, 0, 0, 0);
        check("hwm_deep.Data", 32'(data), 32'h0120);
        for (int i = 0; i < 5; i++) step(0, 16'h0, 0, 1, 0, 0);
        check("hwm_pops.Data", 32'(data), 32'h0125);
`ifdef STACK_POINTER_UNIT_HWM_EN
        check("hwm_pops.highWater", 32'(high_water), 32'h0120);
`endif
        step(1, 16'h0110, 0, 0, 0, 0);
        check("hwm_write.Data", 32'(data), 32'h0110);
`ifdef STACK_POINTER_UNIT_HWM_EN
        check("hwm_write.highWater", 32'(high_water), 32'h0110);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
